brent_kung_operand_recover: RTL and testbench

//  Multi-cycle inverse of the 12-bit BrentKung adder: given the adder's 13-bit sum and one
//  12-bit addend, recovers the other addend (a = sum - b) by digit-serial subtraction.

---
 rtl/brent_kung_operand_recover.sv | 133 +++++++++++++
 tb/tb_brent_kung_operand_recover.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/brent_kung_operand_recover.sv
// rtl/brent_kung_operand_recover.sv - digit-serial recovery of an addend from a BrentKung adder sum
//
// Recovers a = sum - b, working DIGIT bits per cycle from the LSB up, and flags
// results that fall outside the unsigned WIDTH-bit range.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     sum_i/b_i valid
//   in_ready     block is idle and will accept an operation
//   sum_i        adder sum, carry-out in the MSB (WIDTH+1 bits)
//   b_i          known addend (WIDTH bits)
//   out_valid    a_o/range_err_o valid
//   out_ready    consumer accepts the result
//   a_o          recovered addend, (sum_i - b_i) mod 2^WIDTH
//   range_err_o  sum_i - b_i lies outside [0, 2^WIDTH-1]

module brent_kung_operand_recover #(
    parameter int WIDTH = 12,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   sum_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_o,
    output logic             range_err_o
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     sum_q, sum_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               borrow_q, borrow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;

    // One digit of the subtraction; the extra top bit is the borrow out,
    // set exactly when the digit difference went negative.
    logic [DIGIT:0]     diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            b_q      <= '0;
            a_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            b_q      <= b_d;
            a_q      <= a_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        b_d      = b_q;
        a_d      = a_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        err_d    = err_q;

        diff = {1'b0, sum_q[int'(idx_q) * DIGIT +: DIGIT]}
             - {1'b0, b_q[int'(idx_q) * DIGIT +: DIGIT]}
             - {{DIGIT{1'b0}}, borrow_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sum_d    = sum_i;
                    b_d      = b_i;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                a_d[int'(idx_q) * DIGIT +: DIGIT] = diff[DIGIT-1:0];
                borrow_d = diff[DIGIT];
                if (idx_q == LAST_IDX) begin
                    // Carry-out set with no final borrow means sum >= 2^WIDTH;
                    // carry-out clear with a final borrow means sum < b.
                    err_d   = sum_q[WIDTH] ^ diff[DIGIT];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign a_o         = a_q;
    assign range_err_o = err_q;

endmodule

// File: tb/tb_brent_kung_operand_recover.sv
// tb/tb_brent_kung_operand_recover.sv - randomized self-checking bench for brent_kung_operand_recover

module tb_brent_kung_operand_recover;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] sum_i = '0;
    logic [11:0] b_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] a_o;
    logic        range_err_o;

    int checks = 0;
    int errors = 0;

    brent_kung_operand_recover dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum_i      (sum_i),
        .b_i        (b_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a_o        (a_o),
        .range_err_o(range_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Runs one operation. hold = cycles of backpressure in DONE; noise drives
    // random in_valid/inputs while busy, which must all be ignored.
    task automatic run_op(input logic [12:0] s, input logic [11:0] b, input int hold, input bit noise);
        int diff;
        int exp_a;
        int exp_err;
        int lat;
        diff    = int'(s) - int'(b);
        exp_a   = ((diff % 4096) + 4096) % 4096;
        exp_err = (diff < 0 || diff > 4095) ? 1 : 0;

        @(negedge clk);
        check_eq("in_ready_idle", in_ready, 1);
        sum_i    = s;
        b_i      = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = noise ? 1'($urandom) : 1'b0;
        sum_i    = 13'($urandom);
        b_i      = 12'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check_eq("in_ready_calc", in_ready, 0);
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (noise) begin
                in_valid = 1'($urandom);
                sum_i    = 13'($urandom);
                b_i      = 12'($urandom);
            end
        end
        check_eq("latency", lat, 6);
        check_eq("a_o", a_o, exp_a);
        check_eq("range_err", range_err_o, exp_err);
        check_eq("in_ready_done", in_ready, 0);

        for (int i = 0; i < hold; i++) begin
            in_valid = noise ? 1'b1 : in_valid;
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_a", a_o, exp_a);
            check_eq("hold_err", range_err_o, exp_err);
            check_eq("hold_in_ready", in_ready, 0);
        end

        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("released_valid", out_valid, 0);
        check_eq("released_in_ready", in_ready, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_a", a_o, 0);
        check_eq("rst_err", range_err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(13'd8190, 12'd4095, 0, 1'b0);
        run_op(13'd0, 12'd0, 0, 1'b0);
        run_op(13'd1, 12'd1, 0, 1'b0);
        run_op(13'd100, 12'd200, 0, 1'b0);
        run_op(13'd5000, 12'd0, 0, 1'b0);
        run_op(13'd8191, 12'd0, 0, 1'b0);
        run_op(13'd0, 12'd4095, 0, 1'b0);

        // Backpressure with in_valid pulses while DONE
        run_op(13'd4000, 12'd1234, 10, 1'b1);

        // Reset during the third CALC cycle
        @(negedge clk);
        sum_i    = 13'd1234;
        b_i      = 12'd567;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_a", a_o, 0);
        check_eq("midrst_err", range_err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(13'd3000, 12'd1000, 0, 1'b0);

        // Random in-range: sum from a golden adder, a must come back unchanged
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a;
            logic [11:0] b;
            a = 12'($urandom);
            b = 12'($urandom);
            run_op(13'(a) + 13'(b), b, int'($urandom_range(0, 2)), 1'($urandom));
        end

        // Random arbitrary sums, including out-of-range results
        for (int i = 0; i < 1000; i++) begin
            run_op(13'($urandom), 12'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
